// File: rtl/gru_gate_element_seq.sv
// Sequential GRU gate element: two lane-parallel MAC phases (x, h), then a shared sigmoid/tanh stage.
// Optional sticky saturation flag output ovf is built when GRU_GATE_OVF_FLAG_EN is defined.
module gru_gate_element_seq #(
    parameter int D         = 128,
    parameter int H         = 256,
    parameter int INT_BITS  = 16,
    parameter int FRAC_BITS = 8,
    parameter int LANES     = 4,
    localparam int DATA_WIDTH = INT_BITS + FRAC_BITS,
    localparam int ACC_WIDTH  = DATA_WIDTH + $clog2((D > H) ? D : H) + 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         mode,
    input  logic signed [DATA_WIDTH-1:0] b_x,
    input  logic signed [DATA_WIDTH-1:0] b_h,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_w [LANES],
    input  logic signed [DATA_WIDTH-1:0] in_v [LANES],
    output logic                         busy,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_data
`ifdef GRU_GATE_OVF_FLAG_EN
    ,
    output logic                         ovf
`endif
);

    typedef enum logic [2:0] {IDLE, ACC_X, ACC_H, ACT, DONE} state_t;

    localparam int BEATS_X = D / LANES;
    localparam int BEATS_H = H / LANES;
    localparam int CNT_W   = $clog2(((BEATS_X > BEATS_H) ? BEATS_X : BEATS_H) + 1);
    localparam logic [CNT_W-1:0] LAST_X = CNT_W'(BEATS_X - 1);
    localparam logic [CNT_W-1:0] LAST_H = CNT_W'(BEATS_H - 1);

    localparam int EW    = DATA_WIDTH + 1;
    localparam int ONE_I = 1 << FRAC_BITS;
    localparam logic signed [EW-1:0] ONE_E   = EW'(ONE_I);
    localparam logic signed [EW-1:0] SIG_SAT = EW'(5 * ONE_I);
    localparam logic signed [EW-1:0] SIG_K2  = EW'((19 * ONE_I) / 8);
    localparam logic signed [EW-1:0] OFF_3   = EW'((27 * ONE_I) / 32);
    localparam logic signed [EW-1:0] OFF_2   = EW'((5 * ONE_I) / 8);
    localparam logic signed [EW-1:0] OFF_1   = EW'(ONE_I / 2);

    localparam logic signed [ACC_WIDTH-1:0] MAX_A = ACC_WIDTH'({1'b0, {(DATA_WIDTH-1){1'b1}}});
    localparam logic signed [ACC_WIDTH-1:0] MIN_A = ~MAX_A;
    localparam logic signed [ACC_WIDTH-1:0] ONE_A = ACC_WIDTH'(ONE_I);

    function automatic logic signed [ACC_WIDTH-1:0] sext_acc(input logic signed [DATA_WIDTH-1:0] v);
        return {{(ACC_WIDTH-DATA_WIDTH){v[DATA_WIDTH-1]}}, v};
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] sat_data(input logic signed [ACC_WIDTH-1:0] v);
        if (v > MAX_A)
            return MAX_A[DATA_WIDTH-1:0];
        else if (v < MIN_A)
            return MIN_A[DATA_WIDTH-1:0];
        return v[DATA_WIDTH-1:0];
    endfunction

    function automatic logic clips(input logic signed [ACC_WIDTH-1:0] v);
        return (v > MAX_A) || (v < MIN_A);
    endfunction

    // Fixed-point product rescaled by FRAC_BITS; upper bits are dropped, not saturated.
    function automatic logic signed [DATA_WIDTH-1:0] lane_product(input logic signed [DATA_WIDTH-1:0] w,
                                                                  input logic signed [DATA_WIDTH-1:0] v);
        logic signed [2*DATA_WIDTH-1:0] p;
        p = $signed({{DATA_WIDTH{w[DATA_WIDTH-1]}}, w}) * $signed({{DATA_WIDTH{v[DATA_WIDTH-1]}}, v});
        p = p >>> FRAC_BITS;
        return p[DATA_WIDTH-1:0];
    endfunction

    // Piecewise-linear sigmoid on |x| (slopes 1/4, 1/8, 1/32, 0), mirrored for negative inputs.
    function automatic logic signed [DATA_WIDTH-1:0] sigmoid_pla(input logic signed [DATA_WIDTH-1:0] x);
        logic signed [EW-1:0] xe;
        logic signed [EW-1:0] a;
        logic signed [EW-1:0] y;
        xe = {x[DATA_WIDTH-1], x};
        a  = x[DATA_WIDTH-1] ? -xe : xe;
        if (a >= SIG_SAT)
            y = ONE_E;
        else if (a >= SIG_K2)
            y = (a >>> 5) + OFF_3;
        else if (a >= ONE_E)
            y = (a >>> 3) + OFF_2;
        else
            y = (a >>> 2) + OFF_1;
        if (x[DATA_WIDTH-1])
            y = ONE_E - y;
        return y[DATA_WIDTH-1:0];
    endfunction

    state_t                         state, state_d;
    logic                           mode_q;
    logic signed [ACC_WIDTH-1:0]    acc_x, acc_h;
    logic        [CNT_W-1:0]        cnt;
    logic                           hs;
    logic                           job_load;
    logic signed [ACC_WIDTH-1:0]    beat_sum;

    logic signed [DATA_WIDTH-1:0]   sat_x, sat_h, pre_act, tanh_in, sig_arg, sig_y, act_y;
    logic signed [ACC_WIDTH-1:0]    pre_sum, dbl, tanh_raw;
    logic                           act_clip;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d   = state;
        in_ready  = 1'b0;
        busy      = 1'b1;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start)
                    state_d = ACC_X;
            end
            ACC_X: begin
                in_ready = 1'b1;
                if (in_valid && cnt == LAST_X)
                    state_d = ACC_H;
            end
            ACC_H: begin
                in_ready = 1'b1;
                if (in_valid && cnt == LAST_H)
                    state_d = ACT;
            end
            ACT: state_d = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_d = start ? ACC_X : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign hs       = in_valid && in_ready;
    assign job_load = start && ((state == IDLE) || (state == DONE && out_ready));

    // Stage boundary: lane products summed into one beat contribution.
    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < LANES; i++)
            beat_sum = beat_sum + sext_acc(lane_product(in_w[i], in_v[i]));
    end

    // Stage boundary: ACT evaluates both activations through one shared sigmoid.
    always_comb begin
        sat_x    = sat_data(acc_x);
        sat_h    = sat_data(acc_h);
        pre_sum  = sext_acc(sat_x) + sext_acc(sat_h);
        pre_act  = sat_data(pre_sum);
        dbl      = sext_acc(pre_act) <<< 1;
        tanh_in  = sat_data(dbl);
        sig_arg  = mode_q ? tanh_in : pre_act;
        sig_y    = sigmoid_pla(sig_arg);
        tanh_raw = (sext_acc(sig_y) <<< 1) - ONE_A;
        act_y    = mode_q ? sat_data(tanh_raw) : sig_y;
        act_clip = clips(acc_x) || clips(acc_h) || clips(pre_sum) ||
                   (mode_q && (clips(dbl) || clips(tanh_raw)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= 1'b0;
            acc_x    <= '0;
            acc_h    <= '0;
            cnt      <= '0;
            out_data <= '0;
        end else begin
            if (job_load) begin
                mode_q <= mode;
                acc_x  <= sext_acc(b_x);
                acc_h  <= sext_acc(b_h);
                cnt    <= '0;
            end else if (hs) begin
                if (state == ACC_X)
                    acc_x <= acc_x + beat_sum;
                else
                    acc_h <= acc_h + beat_sum;
                if ((state == ACC_X) ? (cnt == LAST_X) : (cnt == LAST_H))
                    cnt <= '0;
                else
                    cnt <= cnt + CNT_W'(1);
            end
            if (state == ACT)
                out_data <= act_y;
        end
    end

`ifdef GRU_GATE_OVF_FLAG_EN
    // Sticky for the current job only; restarts clean with every accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf <= 1'b0;
        else if (job_load)
            ovf <= 1'b0;
        else if (state == ACT && act_clip)
            ovf <= 1'b1;
    end
`else
    logic unused_act_clip;
    assign unused_act_clip = act_clip;
`endif

endmodule
